fill_rect_addr_engine: RTL
==========================

// Module: fill_rect_addr_engine
// PURPOSE
//  Upstream stage of the fill-rect data generator. Accepts one decoded fill-rect command
//  (x, y, hgt, wid, r/g/b) from the decode engine over an rts/rtr handshake and clips it to
//  the screen. Computes the starting word address and starts the data generator.
//  Holds all command fields stable until the data generator returns to idle.
// PARAMETERS
//  SCREEN_W    640  screen width in pixels
//  SCREEN_H    480  screen height in pixels
//  ROW_STRIDE  240  words per pixel row (= SCREEN_W/8 * 3 colour planes)
//  GRP_WORDS   3    words per 8-pixel column group (R,G,B words are consecutive)
// PORTS
//  clk               in   1   clock
//  rst_              in   1   reset, asynchronous, active-low
//  dec_in_rts        in   1   decode engine has a command
//  dec_out_rtr       out  1   this block can accept a command
//  dec_in_x          in   16  rect left pixel column
//  dec_in_y          in   16  rect top pixel row
//  dec_in_hgt        in   16  rect height in rows
//  dec_in_wid        in   16  rect width in columns
//  dec_in_rval/gval/bval  in  4 each  fill colour nibbles
//  data_gen_is_idle  in   1   data generator is in its idle state
//  gen_start_strobe  out  1   start request to data generator (level, held; see below)
//  init_addr         out  16  starting word address of the rect
//  cmd_data_hgt/wid  out  16 each  clipped height/width
//  cmd_data_rval/gval/bval  out  4 each  latched colour
//  cmd_drop          out  1   one-cycle pulse: command consumed but discarded
//  addr_eng_is_idle  out  1   high when state==IDLE
// BEHAVIOUR
//  Reset: all outputs and registers 0 except dec_out_rtr=1 and addr_eng_is_idle=1; state IDLE.
//  xfc = dec_in_rts & dec_out_rtr. dec_out_rtr = (state==IDLE); it is a registered/Moore output.
//  States: IDLE, CALC, STROBE, BUSY.
//   IDLE: on xfc, latch all dec_in_* fields -> CALC.
//   CALC (exactly 1 cycle): drop if wid==0, hgt==0, x>=SCREEN_W or y>=SCREEN_H.
//     On drop: cmd_drop=1 for this cycle, next state IDLE, no strobe, outputs unchanged.
//     Otherwise register:
//       cmd_data_wid = min(wid, SCREEN_W-x); cmd_data_hgt = min(hgt, SCREEN_H-y);
//       init_addr = (y*ROW_STRIDE + (x>>3)*GRP_WORDS) mod 2^16 (17+ bit intermediates);
//       colours = latched values.
//     Next state STROBE.
//   STROBE: gen_start_strobe=1. The generator samples the strobe only when its arbiter is
//     rtr, so the strobe is held until data_gen_is_idle==0, then -> BUSY (strobe 0 next cycle).
//   BUSY: wait for data_gen_is_idle==1 -> IDLE.
//  Outputs cmd_data_* and init_addr stay constant from the end of CALC until the next
//   non-dropped CALC; the generator reads colours combinationally throughout its drive phase.
//  Latency: xfc in cycle T -> CALC in T+1 -> gen_start_strobe high from T+2.
//   Back-to-back: at most one command in flight; rtr returns the cycle after the BUSY exit.
//  Strobe while the generator is already busy: not possible; STROBE is entered only after BUSY.
//   The generator idle at the IDLE->CALC transition is not required.
//  dec_in_* is ignored when xfc==0; x,y,wid,hgt are unsigned.
//  Reset mid-operation: immediate return to reset values; a held strobe drops; latched command lost.
// TESTING
//  x=0,y=0,w=4,h=2,rgb=F/0/8; gen idle -> strobe at T+2, init_addr=0, wid=4, hgt=2, rtr low until gen idle again.
//  x=17,y=3,w=8,h=1 -> init_addr=3*240+2*3=726.
//  x=636,y=478,w=10,h=10 -> cmd_data_wid=4, cmd_data_hgt=2.
//  w=0 (or x=640) -> cmd_drop pulse 1 cycle, no strobe, rtr back high at T+2.
//  Gen holds idle=1 for 5 cycles after strobe -> strobe stays high 5 cycles, drops when idle=0.
//  Assert rst_ low during STROBE -> strobe=0, rtr=1 asynchronously; next command processed normally.

Source files
------------

// File: rtl/fill_rect_addr_engine.sv
// Clips one fill-rect command to the screen and starts the data generator: strobe rises 2 cycles after accept.
// Accepts only when idle; the strobe is held until the generator leaves idle, and rtr returns once it is idle again.
module fill_rect_addr_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int ROW_STRIDE = 240,
  parameter int GRP_WORDS  = 3
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        dec_in_rts,
  output logic        dec_out_rtr,
  input  logic [15:0] dec_in_x,
  input  logic [15:0] dec_in_y,
  input  logic [15:0] dec_in_hgt,
  input  logic [15:0] dec_in_wid,
  input  logic [3:0]  dec_in_rval,
  input  logic [3:0]  dec_in_gval,
  input  logic [3:0]  dec_in_bval,
  input  logic        data_gen_is_idle,
  output logic        gen_start_strobe,
  output logic [15:0] init_addr,
  output logic [15:0] cmd_data_hgt,
  output logic [15:0] cmd_data_wid,
  output logic [3:0]  cmd_data_rval,
  output logic [3:0]  cmd_data_gval,
  output logic [3:0]  cmd_data_bval,
  output logic        cmd_drop,
  output logic        addr_eng_is_idle
);

  typedef enum logic [1:0] {IDLE, CALC, STROBE, BUSY} state_t;

  state_t      state_q;
  logic        rtr_q;
  logic        strobe_q;
  logic        drop_q;
  logic [15:0] x_q, y_q, wid_q, hgt_q;
  logic [3:0]  r_q, g_q, b_q;
  logic [15:0] addr_q, cwid_q, chgt_q;
  logic [3:0]  cr_q, cg_q, cb_q;

  logic        in_drop;
  logic [16:0] x_room, y_room;
  logic [15:0] wid_d, hgt_d, addr_d;

  // Drop decision is taken on the raw fields at accept time and replayed during CALC.
  assign in_drop = (dec_in_wid == 16'd0) || (dec_in_hgt == 16'd0) ||
                   (dec_in_x >= 16'(SCREEN_W)) || (dec_in_y >= 16'(SCREEN_H));

  always_comb begin
    x_room = 17'(SCREEN_W) - {1'b0, x_q};
    y_room = 17'(SCREEN_H) - {1'b0, y_q};
    wid_d  = ({1'b0, wid_q} > x_room) ? x_room[15:0] : wid_q;
    hgt_d  = ({1'b0, hgt_q} > y_room) ? y_room[15:0] : hgt_q;
    // Full-width products, then wrap to the 16-bit word address space.
    addr_d = 16'(32'(y_q) * 32'(ROW_STRIDE) + 32'(x_q >> 3) * 32'(GRP_WORDS));
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      rtr_q    <= 1'b1;
      strobe_q <= 1'b0;
      drop_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      wid_q    <= '0;
      hgt_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      cwid_q   <= '0;
      chgt_q   <= '0;
      cr_q     <= '0;
      cg_q     <= '0;
      cb_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dec_in_rts && rtr_q) begin
            x_q     <= dec_in_x;
            y_q     <= dec_in_y;
            wid_q   <= dec_in_wid;
            hgt_q   <= dec_in_hgt;
            r_q     <= dec_in_rval;
            g_q     <= dec_in_gval;
            b_q     <= dec_in_bval;
            drop_q  <= in_drop;
            rtr_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          drop_q <= 1'b0;
          if (drop_q) begin
            rtr_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            addr_q   <= addr_d;
            cwid_q   <= wid_d;
            chgt_q   <= hgt_d;
            cr_q     <= r_q;
            cg_q     <= g_q;
            cb_q     <= b_q;
            strobe_q <= 1'b1;
            state_q  <= STROBE;
          end
        end
        STROBE: begin
          // The generator only sees the strobe once its arbiter is ready; hold until it leaves idle.
          if (!data_gen_is_idle) begin
            strobe_q <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (data_gen_is_idle) begin
            rtr_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_out_rtr      = rtr_q;
  assign addr_eng_is_idle = rtr_q;
  assign gen_start_strobe = strobe_q;
  assign cmd_drop         = drop_q;
  assign init_addr        = addr_q;
  assign cmd_data_wid     = cwid_q;
  assign cmd_data_hgt     = chgt_q;
  assign cmd_data_rval    = cr_q;
  assign cmd_data_gval    = cg_q;
  assign cmd_data_bval    = cb_q;

endmodule
